branch_predict_ctrl: RTL and testbench

- Controller sequencing the branch target buffer and the pipeline on branch resolution.
- Holds a 2-bit saturating direction counter per BTB entry and produces the IF-stage prediction (taken + target) from BTB read data.
- At MEM-stage resolution it decides BTB writes, counter updates and mispredict recovery.
- Recovery is a flush/redirect FSM with a handshake to the hazard unit.

---
 rtl/branch_buffer_types_pkg.sv | 17 +
 rtl/sat_counter2.sv | 19 +
 rtl/branch_predict_ctrl.sv | 114 +++++++++++
 tb/tb_branch_predict_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_buffer_types_pkg.sv
// Shared types for the branch predictor: FSM states and 2-bit direction counter values.
package branch_buffer_types_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DRAIN
    } bpstate_t;

    typedef logic [1:0] cnt_t;

    localparam cnt_t SNT = 2'd0;
    localparam cnt_t WNT = 2'd1;
    localparam cnt_t WT  = 2'd2;
    localparam cnt_t ST  = 2'd3;

endpackage

// File: rtl/sat_counter2.sv
// Next-value logic for a 2-bit saturating direction counter.
module sat_counter2
    import branch_buffer_types_pkg::*;
(
    input  cnt_t cnt_in,
    input  logic inc,
    output cnt_t cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (inc) begin
            if (cnt_in != ST) cnt_out = cnt_in + 2'd1;
        end else begin
            if (cnt_in != SNT) cnt_out = cnt_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor controller: IF prediction from BTB data, MEM-stage resolution and
// flush/redirect recovery. Define BRANCH_STATS_EN to add br_count/mis_count outputs.
module branch_predict_ctrl
    import branch_buffer_types_pkg::*;
#(
    parameter int unsigned ENTRIES  = 4,
    parameter int unsigned IDX_W    = 2,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [31:0]           IFpc,
    input  logic                  PRvalid,
    input  logic [31-IDX_W-2:0]   PRtag,
    input  logic [31:0]           PRbpc,
    output logic                  pred_taken,
    output logic [31:0]           pred_pc,
    input  logic                  MMvalid,
    input  logic                  MMisbr,
    input  logic                  MMtaken,
    input  logic [31:0]           MMpc,
    input  logic [31:0]           MMbpc,
    input  logic                  MMpredtaken,
    input  logic [31:0]           MMpredpc,
    input  logic                  pipe_stall,
    input  logic                  flush_ack,
    output logic                  bb_wen,
    output logic                  flush_req,
    output logic [31:0]           redirect_pc,
    output logic                  mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           br_count,
    output logic [31:0]           mis_count
`endif
);

    cnt_t             cnt [ENTRIES];
    cnt_t             cnt_next;
    bpstate_t         state;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] mm_idx;
    logic             hit;
    logic             res;
    logic             mis;
    logic [31:0]      actual_pc;
    logic             unused_predtaken;

    assign if_idx = IFpc[IDX_W+1:2];
    assign mm_idx = MMpc[IDX_W+1:2];

    assign hit        = PRvalid && (PRtag == IFpc[31:IDX_W+2]);
    assign pred_taken = hit && cnt[if_idx][1];
    assign pred_pc    = pred_taken ? PRbpc : IFpc + 32'd4;

    // Direction is implied by the predicted PC, so only the PC compare matters.
    assign unused_predtaken = MMpredtaken;

    assign actual_pc  = MMtaken ? MMbpc : MMpc + 32'd4;
    assign res        = nRST && MMvalid && MMisbr && !pipe_stall && (state == IDLE);
    assign mis        = res && (actual_pc != MMpredpc);
    assign bb_wen     = res && MMtaken;
    assign mispredict = mis;

    sat_counter2 u_sat (
        .cnt_in  (cnt[mm_idx]),
        .inc     (MMtaken),
        .cnt_out (cnt_next)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < int'(ENTRIES); i++) cnt[i] <= CNT_INIT;
            state       <= IDLE;
            flush_req   <= 1'b0;
            redirect_pc <= '0;
        end else begin
            if (res) cnt[mm_idx] <= cnt_next;
            unique case (state)
                IDLE: begin
                    if (mis) begin
                        state       <= FLUSH;
                        flush_req   <= 1'b1;
                        redirect_pc <= actual_pc;
                    end
                end
                FLUSH: begin
                    if (flush_ack) begin
                        state     <= DRAIN;
                        flush_req <= 1'b0;
                    end
                end
                DRAIN: state <= IDLE;
                default: begin
                    state     <= IDLE;
                    flush_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (res && (br_count != 32'hFFFF_FFFF)) br_count <= br_count + 32'd1;
            if (mis && (mis_count != 32'hFFFF_FFFF)) mis_count <= mis_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios plus a randomized run
// against a behavioural model.
module tb_branch_predict_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] IFpc;
    logic        PRvalid;
    logic [27:0] PRtag;
    logic [31:0] PRbpc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        MMvalid, MMisbr, MMtaken, MMpredtaken;
    logic [31:0] MMpc, MMbpc, MMpredpc;
    logic        pipe_stall, flush_ack;
    logic        bb_wen, flush_req, mispredict;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count, mis_count;
`endif

    int checks = 0;
    int errors = 0;

    branch_predict_ctrl dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .IFpc        (IFpc),
        .PRvalid     (PRvalid),
        .PRtag       (PRtag),
        .PRbpc       (PRbpc),
        .pred_taken  (pred_taken),
        .pred_pc     (pred_pc),
        .MMvalid     (MMvalid),
        .MMisbr      (MMisbr),
        .MMtaken     (MMtaken),
        .MMpc        (MMpc),
        .MMbpc       (MMbpc),
        .MMpredtaken (MMpredtaken),
        .MMpredpc    (MMpredpc),
        .pipe_stall  (pipe_stall),
        .flush_ack   (flush_ack),
        .bb_wen      (bb_wen),
        .flush_req   (flush_req),
        .redirect_pc (redirect_pc),
        .mispredict  (mispredict)
`ifdef BRANCH_STATS_EN
        ,
        .br_count    (br_count),
        .mis_count   (mis_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mm_clear();
        MMvalid = 0; MMisbr = 0; MMtaken = 0; MMpredtaken = 0;
        MMpc = 0; MMbpc = 0; MMpredpc = 0;
    endtask

    task automatic mm_branch(input logic [31:0] pc, input logic taken,
                             input logic [31:0] bpc, input logic [31:0] predpc);
        MMvalid = 1; MMisbr = 1; MMtaken = taken; MMpc = pc; MMbpc = bpc;
        MMpredpc = predpc; MMpredtaken = (predpc != pc + 32'd4);
    endtask

    task automatic do_reset();
        nRST = 0; IFpc = 0; PRvalid = 0; PRtag = 0; PRbpc = 0;
        pipe_stall = 0; flush_ack = 0;
        mm_clear();
        tick();
        tick();
        nRST = 1;
    endtask

    task automatic test_reset();
        do_reset();
        IFpc = 32'h40; PRvalid = 1; PRtag = 28'h4; PRbpc = 32'h80;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++;
            $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
        checks++; if (pred_pc !== 32'h44) begin errors++;
            $display("FAIL reset_pred_pc got %h want 00000044", pred_pc); end
        checks++; if ({bb_wen, flush_req, mispredict} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl got %b want 000", {bb_wen, flush_req, mispredict}); end
        checks++; if (redirect_pc !== 32'h0) begin errors++;
            $display("FAIL reset_redirect got %h want 0", redirect_pc); end
        IFpc = 32'hFFFF_FFFC; PRvalid = 0;
        #1;
        checks++; if (pred_pc !== 32'h0) begin errors++;
            $display("FAIL pc_wrap got %h want 00000000", pred_pc); end
        IFpc = 32'h40; PRvalid = 1;
    endtask

    task automatic test_mispredict_flush();
        // Counter 01 -> taken resolution, predicted not-taken.
        mm_branch(32'h40, 1, 32'h80, 32'h44);
        #1;
        checks++; if ({bb_wen, mispredict} !== 2'b11) begin errors++;
            $display("FAIL mp_detect got %b want 11", {bb_wen, mispredict}); end
        checks++; if (pred_taken !== 1'b0) begin errors++;
            $display("FAIL mp_war got %0b want 0", pred_taken); end
        tick();
        mm_clear();
        #1;
        checks++; if ({flush_req, mispredict, bb_wen} !== 3'b100) begin errors++;
            $display("FAIL mp_flush got %b want 100", {flush_req, mispredict, bb_wen}); end
        checks++; if (redirect_pc !== 32'h80) begin errors++;
            $display("FAIL mp_redirect got %h want 00000080", redirect_pc); end
        checks++; if (pred_taken !== 1'b1) begin errors++;
            $display("FAIL mp_cnt2 got %0b want 1", pred_taken); end
        // Flush holds without ack even with stall; a branch in MEM is ignored.
        pipe_stall = 1;
        tick();
        pipe_stall = 0;
        mm_branch(32'h40, 1, 32'h80, 32'h80);
        #1;
        checks++; if ({flush_req, bb_wen} !== 2'b10) begin errors++;
            $display("FAIL flush_hold got %b want 10", {flush_req, bb_wen}); end
        flush_ack = 1;
        tick();
        flush_ack = 0;
        #1;
        checks++; if ({flush_req, bb_wen} !== 2'b00) begin errors++;
            $display("FAIL drain got %b want 00", {flush_req, bb_wen}); end
        tick();
        // Back in IDLE: two correctly predicted taken resolutions (2->3->3).
        checks++; if ({bb_wen, mispredict, flush_req} !== 3'b100) begin errors++;
            $display("FAIL idle_res got %b want 100", {bb_wen, mispredict, flush_req}); end
        tick();
        tick();
        mm_branch(32'h40, 0, 32'h80, 32'h80);
        #1;
        checks++; if ({bb_wen, mispredict} !== 2'b01) begin errors++;
            $display("FAIL nt_detect got %b want 01", {bb_wen, mispredict}); end
        tick();
        mm_clear();
        #1;
        checks++; if (redirect_pc !== 32'h44 || flush_req !== 1'b1) begin errors++;
            $display("FAIL nt_redirect got %h/%0b want 00000044/1", redirect_pc, flush_req); end
        checks++; if (pred_taken !== 1'b1) begin errors++;
            $display("FAIL sat_cnt got %0b want 1", pred_taken); end
        flush_ack = 1;
        tick();
        flush_ack = 0;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        IFpc = 32'h48; PRvalid = 1; PRtag = 28'h4; PRbpc = 32'h90;
        mm_branch(32'h48, 1, 32'h90, 32'h90);
        pipe_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bb_wen !== 1'b0) begin errors++;
                $display("FAIL stall_wen cycle %0d got %0b want 0", i, bb_wen); end
            tick();
        end
        pipe_stall = 0;
        #1;
        checks++; if ({bb_wen, mispredict} !== 2'b10) begin errors++;
            $display("FAIL stall_release got %b want 10", {bb_wen, mispredict}); end
        tick();
        checks++; if (pred_taken !== 1'b1) begin errors++;
            $display("FAIL stall_step got %0b want 1", pred_taken); end
        // One not-taken step must bring it back to 01.
        mm_branch(32'h48, 0, 32'h90, 32'h4C);
        tick();
        mm_clear();
        #1;
        checks++; if (pred_taken !== 1'b0 || flush_req !== 1'b0) begin errors++;
            $display("FAIL stall_once got %0b/%0b want 0/0", pred_taken, flush_req); end
    endtask

    task automatic test_stale_target_and_reset();
        do_reset();
        mm_branch(32'h40, 1, 32'h80, 32'h100);
        #1;
        checks++; if ({bb_wen, mispredict} !== 2'b11) begin errors++;
            $display("FAIL stale_detect got %b want 11", {bb_wen, mispredict}); end
        tick();
        mm_clear();
        #1;
        checks++; if (redirect_pc !== 32'h80 || flush_req !== 1'b1) begin errors++;
            $display("FAIL stale_redirect got %h/%0b want 00000080/1", redirect_pc, flush_req); end
        nRST = 0;
        tick();
        nRST = 1;
        IFpc = 32'h40; PRvalid = 1; PRtag = 28'h4;
        #1;
        checks++; if (flush_req !== 1'b0 || redirect_pc !== 32'h0) begin errors++;
            $display("FAIL rst_abort got %0b/%h want 0/0", flush_req, redirect_pc); end
        checks++; if (pred_taken !== 1'b0) begin errors++;
            $display("FAIL rst_cnt got %0b want 0", pred_taken); end
        mm_branch(32'h40, 1, 32'h80, 32'h80);
        #1;
        checks++; if (bb_wen !== 1'b1) begin errors++;
            $display("FAIL rst_idle got %0b want 1", bb_wen); end
        tick();
        mm_clear();
    endtask

    // Behavioural model state.
    int          mcnt [4];
    bit          m_flush, m_drain;
    logic [31:0] m_redir;
    longint      m_br, m_mis;

    task automatic test_random();
        logic [31:0] actual;
        logic [31:0] e_ppc;
        bit          e_pt, e_res, e_mis, hitm;
        int          ii, mi;
        do_reset();
        for (int i = 0; i < 4; i++) mcnt[i] = 1;
        m_flush = 0; m_drain = 0; m_redir = 0; m_br = 0; m_mis = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            IFpc    = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            PRvalid = 1'($urandom);
            PRtag   = ($urandom_range(0, 3) != 0) ? IFpc[31:4] : 28'($urandom);
            PRbpc   = $urandom;
            MMvalid = ($urandom_range(0, 3) != 0);
            MMisbr  = ($urandom_range(0, 3) != 0);
            MMtaken = 1'($urandom);
            MMpc    = {24'h0, 6'($urandom), 2'b00};
            MMbpc   = {24'h0, 6'($urandom), 2'b00};
            case ($urandom_range(0, 2))
                0: MMpredpc = MMpc + 32'd4;
                1: MMpredpc = MMbpc;
                default: MMpredpc = {24'h0, 6'($urandom), 2'b00};
            endcase
            MMpredtaken = 1'($urandom);
            pipe_stall  = ($urandom_range(0, 4) == 0);
            flush_ack   = ($urandom_range(0, 2) == 0);
            #1;
            ii     = int'(IFpc[3:2]);
            mi     = int'(MMpc[3:2]);
            hitm   = PRvalid && (PRtag == IFpc[31:4]);
            e_pt   = hitm && (mcnt[ii] >= 2);
            e_ppc  = e_pt ? PRbpc : IFpc + 32'd4;
            actual = MMtaken ? MMbpc : MMpc + 32'd4;
            e_res  = MMvalid && MMisbr && !pipe_stall && !m_flush && !m_drain;
            e_mis  = e_res && (actual != MMpredpc);
            checks++; if (pred_taken !== e_pt || pred_pc !== e_ppc) begin errors++;
                $display("FAIL rnd_pred cyc %0d got %0b/%h want %0b/%h",
                         cyc, pred_taken, pred_pc, e_pt, e_ppc); end
            checks++; if (bb_wen !== (e_res && MMtaken) || mispredict !== e_mis) begin errors++;
                $display("FAIL rnd_res cyc %0d got %0b/%0b want %0b/%0b",
                         cyc, bb_wen, mispredict, e_res && MMtaken, e_mis); end
            @(posedge CLK);
            if (e_res) mcnt[mi] = MMtaken ? ((mcnt[mi] < 3) ? mcnt[mi] + 1 : 3)
                                          : ((mcnt[mi] > 0) ? mcnt[mi] - 1 : 0);
            if (e_res) m_br++;
            if (e_mis) m_mis++;
            if (m_drain) m_drain = 0;
            else if (m_flush) begin
                if (flush_ack) begin m_flush = 0; m_drain = 1; end
            end else if (e_mis) begin
                m_flush = 1; m_redir = actual;
            end
            #1;
            checks++; if (flush_req !== m_flush || redirect_pc !== m_redir) begin errors++;
                $display("FAIL rnd_flush cyc %0d got %0b/%h want %0b/%h",
                         cyc, flush_req, redirect_pc, m_flush, m_redir); end
`ifdef BRANCH_STATS_EN
            checks++; if (br_count !== 32'(m_br) || mis_count !== 32'(m_mis)) begin errors++;
                $display("FAIL rnd_stats cyc %0d got %0d/%0d want %0d/%0d",
                         cyc, br_count, mis_count, m_br, m_mis); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_mispredict_flush();
        test_stall();
        test_stale_target_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
